// File: rtl/trace_stamp_fifo.sv
// trace_stamp_fifo: capture FIFO that tags every accepted word with a
// free-running 32-bit cycle stamp, with drop accounting and flush.
module trace_stamp_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_in_valid,
    input  logic [DW-1:0]            io_in_bits,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [DW-1:0]            io_out_data,
    output logic [31:0]              io_out_stamp,
    input  logic                     io_clear,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic [7:0]               io_drops,
    output logic                     io_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   tsc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [DW-1:0] data_mem  [DEPTH];
    logic [31:0]   stamp_mem [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic drop;

    // Handshake qualification; io_clear masks everything in its cycle.
    always_comb begin
        full = (io_count == FULL_CNT);
        pop  = io_out_valid && io_out_ready && !io_clear;
        push = io_in_valid && !io_clear && (!full || pop);
        drop = io_in_valid && !io_clear && !push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tsc <= '0;
        end else begin
            tsc <= tsc + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (io_clear) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (io_clear) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_count <= '0;
        end else if (io_clear) begin
            io_count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   io_count <= io_count + CNT_ONE;
                2'b01:   io_count <= io_count - CNT_ONE;
                default: io_count <= io_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_drops    <= '0;
            io_overflow <= 1'b0;
        end else if (io_clear) begin
            io_drops    <= '0;
            io_overflow <= 1'b0;
        end else if (drop) begin
            io_overflow <= 1'b1;
            if (io_drops != 8'hFF) begin
                io_drops <= io_drops + 8'd1;
            end
        end
    end

    // Storage carries no reset; contents only matter while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr]  <= io_in_bits;
            stamp_mem[wr_ptr] <= tsc;
        end
    end

    always_comb begin
        io_out_valid = (io_count != '0);
        io_out_data  = data_mem[rd_ptr];
        io_out_stamp = stamp_mem[rd_ptr];
    end

endmodule

// File: tb/tb_trace_stamp_fifo.sv
// tb_trace_stamp_fifo: directed table, corner sequences and random
// traffic against a queue-based reference of the stamp FIFO.
module tb_trace_stamp_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_in_valid;
    logic [DW-1:0] io_in_bits;
    logic          io_out_valid;
    logic          io_out_ready;
    logic [DW-1:0] io_out_data;
    logic [31:0]   io_out_stamp;
    logic          io_clear;
    logic [CW-1:0] io_count;
    logic [7:0]    io_drops;
    logic          io_overflow;

    trace_stamp_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_data  (io_out_data),
        .io_out_stamp (io_out_stamp),
        .io_clear     (io_clear),
        .io_count     (io_count),
        .io_drops     (io_drops),
        .io_overflow  (io_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] b;
        logic          r;
        logic          c;
        int            cnt;
        logic          ov;
        logic [DW-1:0] dat;
        logic [31:0]   stp;
        int            drp;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [31:0]   s;
    } ent_t;

    vec_t        tbl [20];
    ent_t        q [$];
    logic [31:0] m_tsc;
    int          m_drops;
    logic        m_ovf;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tsc   = 32'd0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_model();
        chk("m_count", 32'(io_count), 32'(q.size()));
        chk("m_valid", 32'(io_out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_data", 32'(io_out_data), 32'(q[0].d));
            chk("m_stamp", io_out_stamp, q[0].s);
        end
        chk("m_drops", 32'(io_drops), 32'(m_drops));
        chk("m_ovf", 32'(io_overflow), 32'(m_ovf));
        chk("m_tsc", dut.tsc, m_tsc);
    endtask

    // One clock: drive inputs, advance the reference, sample after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] b,
                         input logic r, input logic c);
        bit do_pop;
        bit do_push;
        io_in_valid  = v;
        io_in_bits   = b;
        io_out_ready = r;
        io_clear     = c;
        do_pop  = (q.size() != 0) && r && !c;
        do_push = v && !c && (q.size() < DEPTH || do_pop);
        if (c) begin
            q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{d: b, s: m_tsc});
            if (v && !do_push) begin
                if (m_drops < 255) m_drops++;
                m_ovf = 1'b1;
            end
        end
        m_tsc = m_tsc + 32'd1;
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] t0;
        int          pv;
        int          pr;

        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_out_ready = 1'b0;
        io_clear     = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(io_out_valid), 32'd0);
        chk("rst_count", 32'(io_count), 32'd0);
        chk("rst_drops", 32'(io_drops), 32'd0);
        chk("rst_ovf", 32'(io_overflow), 32'd0);
        io_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tsc", dut.tsc, 32'd0);
        chk("rst_nodrop", 32'(io_drops), 32'd0);
        io_in_valid = 1'b0;
        reset = 1'b1;

        // Directed table: push-no-bypass, overfill, full push+pop, drain, clear.
        tbl[0] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1, 1'b1, 16'h1234, 32'd0, 0, 1'b0};
        for (int i = 1; i <= 9; i++) begin
            tbl[i] = '{1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0,
                       (i < 8) ? i + 1 : 8, 1'b1, 16'h1234, 32'd0,
                       (i < 8) ? 0 : i - 7, (i >= 8)};
        end
        tbl[10] = '{1'b1, 16'hB000, 1'b1, 1'b0, 8, 1'b1, 16'hA001, 32'd1, 2, 1'b1};
        for (int k = 11; k <= 16; k++) begin
            tbl[k] = '{1'b0, 16'h0, 1'b1, 1'b0, 18 - k, 1'b1,
                       16'hA000 + 16'(k - 9), 32'(k - 9), 2, 1'b1};
        end
        tbl[17] = '{1'b0, 16'h0, 1'b1, 1'b0, 1, 1'b1, 16'hB000, 32'd10, 2, 1'b1};
        tbl[18] = '{1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0, 16'h0, 32'd0, 2, 1'b1};
        tbl[19] = '{1'b1, 16'h5555, 1'b0, 1'b1, 0, 1'b0, 16'h0, 32'd0, 0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].r, tbl[i].c);
            chk($sformatf("t%0d_count", i), 32'(io_count), 32'(tbl[i].cnt));
            chk($sformatf("t%0d_valid", i), 32'(io_out_valid), 32'(tbl[i].ov));
            chk($sformatf("t%0d_drops", i), 32'(io_drops), 32'(tbl[i].drp));
            chk($sformatf("t%0d_ovf", i), 32'(io_overflow), 32'(tbl[i].ovf));
            if (tbl[i].ov) begin
                chk($sformatf("t%0d_data", i), 32'(io_out_data), 32'(tbl[i].dat));
                chk($sformatf("t%0d_stamp", i), io_out_stamp, tbl[i].stp);
            end
        end

        // Clear with 5 entries and 3 drops, capture in the same cycle.
        for (int i = 0; i < 11; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("clr_pre_count", 32'(io_count), 32'd5);
        chk("clr_pre_drops", 32'(io_drops), 32'd3);
        t0 = dut.tsc;
        cycle(1'b1, 16'hDEAD, 1'b1, 1'b1);
        chk("clr_count", 32'(io_count), 32'd0);
        chk("clr_valid", 32'(io_out_valid), 32'd0);
        chk("clr_drops", 32'(io_drops), 32'd0);
        chk("clr_ovf", 32'(io_overflow), 32'd0);
        chk("clr_tsc", dut.tsc, t0 + 32'd1);

        // Stamp wrap across 0xFFFFFFFF.
        force dut.tsc = 32'hFFFF_FFFE;
        #1;
        release dut.tsc;
        m_tsc = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
        chk("wrap_s0", io_out_stamp, 32'hFFFF_FFFE);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wrap_s1", io_out_stamp, 32'hFFFF_FFFF);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wrap_s2", io_out_stamp, 32'h0000_0000);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with 4 entries buffered.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hF000 + 16'(i), 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(io_out_valid), 32'd0);
        chk("arst_count", 32'(io_count), 32'd0);
        io_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_drops", 32'(io_drops), 32'd0);
        chk("arst_tsc", dut.tsc, 32'd0);
        io_in_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        cycle(1'b1, 16'h0BAD, 1'b0, 1'b0);
        chk("arst_first_stamp", io_out_stamp, 32'd0);
        for (int i = 0; i < 307; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        chk("sat_drops", 32'(io_drops), 32'd255);
        chk("sat_ovf", 32'(io_overflow), 32'd1);
        chk("sat_count", 32'(io_count), 32'(DEPTH));

        // Random traffic with phase-varying push/pop pressure.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            pv = 30 + 12 * p;
            pr = 90 - 12 * p;
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(0, 99) < pv, 16'($urandom),
                      $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_stamp_fifo.md
TRACE_STAMP_FIFO -- requirements
Module: trace_stamp_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, 2..64).
REQ-002 The block SHALL have parameter DW, default 16, meaning captured data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 io_in_valid  in  1  capture request this cycle.
REQ-007 io_in_bits  in  DW  data to capture (upstream packed word, e.g. {x,y}).
REQ-008 io_out_valid  out  1  head entry available.
REQ-009 io_out_ready  in  1  consumer accepts head entry.
REQ-010 io_out_data  out  DW  head entry data.
REQ-011 io_out_stamp  out  32  head entry cycle stamp.
REQ-012 io_clear  in  1  synchronous flush request.
REQ-013 io_count  out  log2(DEPTH)+1  current occupancy.
REQ-014 io_drops  out  8  saturating count of dropped captures.
REQ-015 io_overflow  out  1  sticky: at least one drop since reset/clear.

Function
REQ-016 The block SHALL hold a free-running 32-bit cycle counter tsc, +1 every cycle, wrapping 0xFFFFFFFF->0, never affected by io_clear.
REQ-017 A push SHALL occur when io_in_valid=1, io_clear=0, and (count<DEPTH or a pop occurs the same cycle).
REQ-018 A pushed entry SHALL store {io_in_bits, tsc value of the push cycle}.
REQ-019 A pop SHALL occur when io_out_valid=1, io_out_ready=1 and io_clear=0.
REQ-020 io_out_valid SHALL equal (count!=0); io_out_data/io_out_stamp SHALL show the oldest entry (first-word fall-through) and are don't-care when io_out_valid=0.
REQ-021 Latency SHALL be exactly one cycle: an entry pushed in cycle N is visible at the head in cycle N+1 at earliest.
REQ-022 Push into an empty FIFO with io_out_ready=1 SHALL NOT bypass; io_out_valid rises the next cycle.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-024 io_in_valid=1 with count=DEPTH and no pop SHALL drop the capture: FIFO unchanged, io_drops +1 saturating at 255, io_overflow set.
REQ-025 io_clear=1 SHALL, next cycle, set count=0, io_drops=0, io_overflow=0; any push or pop in that cycle is discarded and not counted as a drop.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; full vs. empty distinguished by count (or extra pointer bit).
REQ-027 io_count SHALL be registered and reflect occupancy after the previous edge.

Reset
REQ-028 Reset assertion SHALL immediately (asynchronously) force tsc=0, count=0, pointers=0, io_drops=0, io_overflow=0, io_out_valid=0.
REQ-029 Entry storage SHALL NOT require reset; contents are don't-care while count=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; after release, the first captured entry's stamp equals cycles elapsed since the first post-release edge (first edge stamps 0).
REQ-031 Under reset, io_in_valid SHALL have no effect and SHALL NOT increment io_drops.

Verification
REQ-032 Release reset, push 0x1234 at the first edge (tsc=0) -> next cycle io_out_valid=1, io_out_data=0x1234, io_out_stamp=0, io_count=1.
REQ-033 io_out_ready=0, push 10 words on consecutive cycles, DEPTH=8 -> io_count=8, io_drops=2, io_overflow=1; drain yields first 8 words in order with stamps increasing by 1.
REQ-034 FIFO full, io_in_valid=1 and io_out_ready=1 same cycle -> io_count stays 8, io_drops unchanged, new entry at tail.
REQ-035 Force tsc to 0xFFFFFFFE, push on 3 consecutive cycles -> stamps 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-036 With 5 entries and io_drops=3, assert io_clear with io_in_valid=1 -> next cycle io_count=0, io_out_valid=0, io_drops=0, io_overflow=0; tsc continues uninterrupted.
REQ-037 Assert reset asynchronously between edges with 4 entries buffered -> io_out_valid=0, io_count=0 before the next clk edge; 300 forced drops after release -> io_drops=255.
